dmem_mmio_responder: RTL and testbench



---
 rtl/dmem_mmio_responder_pkg.sv | 34 +++
 rtl/dmem_mmio_responder_if.sv | 23 ++
 rtl/dmem_mmio_responder_fifo.sv | 54 +++++
 rtl/dmem_mmio_responder.sv | 85 ++++++++
 tb/tb_dmem_mmio_responder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// dmem_map_pkg: I/O map and TXSTAT layout for the CPU data-port responder.
// Holds the MMIO address constants, the TXSTAT bit positions, the decode
// selector type, and a helper that packs the TXSTAT word.
package dmem_map_pkg;

    localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_TXDATA = IO_BASE;
    localparam logic [31:0] ADDR_TXSTAT = IO_BASE + 32'h4;
    localparam logic [31:0] ADDR_CYCLE  = IO_BASE + 32'h8;

    localparam int TXSTAT_FULL_BIT  = 0;
    localparam int TXSTAT_EMPTY_BIT = 1;
    localparam int TXSTAT_COUNT_LSB = 8;
    localparam int TXSTAT_COUNT_W   = 8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TXDATA,
        SEL_TXSTAT,
        SEL_CYCLE
    } dmem_sel_e;

    function automatic logic [31:0] txstat_word(input logic full, input logic empty,
                                                input logic [TXSTAT_COUNT_W-1:0] count);
        logic [31:0] w;
        w = '0;
        w[TXSTAT_FULL_BIT]  = full;
        w[TXSTAT_EMPTY_BIT] = empty;
        w[TXSTAT_COUNT_LSB +: TXSTAT_COUNT_W] = count;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// CPU data port plus the byte-sink handshake.
//   master: CPU/board side (drives address, store, tx_ready)
//   slave : responder side (drives load data, cpu_ena, tx_data/tx_valid)
interface dmem_mmio_responder_if;
    logic [31:0] DMEM_addr;
    logic [31:0] DMEM_wdata;
    logic        DMEM_we;
    logic [31:0] DMEM_rdata;
    logic        cpu_ena;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output DMEM_addr, DMEM_wdata, DMEM_we, tx_ready,
        input  DMEM_rdata, cpu_ena, tx_data, tx_valid
    );

    modport slave (
        input  DMEM_addr, DMEM_wdata, DMEM_we, tx_ready,
        output DMEM_rdata, cpu_ena, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_mmio_responder_fifo.sv
// tx_byte_fifo: circular byte FIFO with a registered occupancy count.
//   clk, reset      : clock, async active-high reset (flushes contents)
//   push, push_data : enqueue request; ignored while full
//   pop             : dequeue request; ignored while empty
//   head            : oldest byte, 0 when empty
//   full, empty     : occupancy flags derived from count
//   count           : entries held, 0..FIFO_DEPTH
module tx_byte_fifo #(
    parameter int FIFO_DEPTH = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    // A push against a full FIFO is dropped even if a pop frees a slot this
    // cycle; the stalled store lands on the next cycle instead.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; a zero count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-memory side of the CPU data port.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of the data port and the TX byte sink
// Serves a word RAM at the bottom of the address space, a TX byte FIFO
// (TXDATA/TXSTAT) and a free-running cycle counter (CYCLE) in I/O space,
// and stalls the CPU while it stores into a full TX FIFO.
module dmem_mmio_responder
    import dmem_map_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    dmem_mmio_responder_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       ram [2**RAM_AW];
    logic [31:0]       word_addr;
    logic [RAM_AW-1:0] ram_idx;
    dmem_sel_e         sel;
    logic [31:0]       cycle_cnt;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [7:0]        fifo_head;
    logic              tx_wr, ram_we;
    logic              unused_byte_lanes;

    // Word access only: the byte offset is dropped before decode.
    assign word_addr         = {bus.DMEM_addr[31:2], 2'b00};
    assign ram_idx           = bus.DMEM_addr[RAM_AW+1:2];
    assign unused_byte_lanes = ^bus.DMEM_addr[1:0];

    always_comb begin
        sel = SEL_NONE;
        if (bus.DMEM_addr[31:RAM_AW+2] == '0) sel = SEL_RAM;
        else if (word_addr == ADDR_TXDATA)    sel = SEL_TXDATA;
        else if (word_addr == ADDR_TXSTAT)    sel = SEL_TXSTAT;
        else if (word_addr == ADDR_CYCLE)     sel = SEL_CYCLE;
    end

    assign tx_wr       = bus.DMEM_we && (sel == SEL_TXDATA);
    assign bus.cpu_ena = !(tx_wr && fifo_full);
    assign ram_we      = bus.DMEM_we && (sel == SEL_RAM) && bus.cpu_ena;

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= bus.DMEM_wdata;
    end

    // A CYCLE store takes priority over the increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 cycle_cnt <= '0;
        else if (bus.DMEM_we && sel == SEL_CYCLE)  cycle_cnt <= bus.DMEM_wdata;
        else                                       cycle_cnt <= cycle_cnt + 32'd1;
    end

    tx_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_wr),
        .push_data (bus.DMEM_wdata[7:0]),
        .pop       (bus.tx_valid && bus.tx_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.tx_data  = fifo_head;
    assign bus.tx_valid = !fifo_empty;

    always_comb begin
        bus.DMEM_rdata = '0;
        unique case (sel)
            SEL_RAM:    bus.DMEM_rdata = ram[ram_idx];
            SEL_TXSTAT: bus.DMEM_rdata = txstat_word(fifo_full, fifo_empty,
                                                     TXSTAT_COUNT_W'(fifo_count));
            SEL_CYCLE:  bus.DMEM_rdata = cycle_cnt;
            default:    bus.DMEM_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;
    import dmem_map_pkg::*;

    localparam int RAM_AW = 10;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_mmio_responder_if bus();

    dmem_mmio_responder #(.RAM_AW(RAM_AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: RAM as a sparse map, FIFO as a queue, counter as a value.
    logic [31:0] mem_m [int];
    logic [7:0]  q [$];
    logic [31:0] cyc_m = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wa(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic bit is_ram(input logic [31:0] a);
        return a[31:RAM_AW+2] == '0;
    endfunction

    function automatic bit model_stall();
        return bus.DMEM_we && !is_ram(bus.DMEM_addr) && wa(bus.DMEM_addr) == ADDR_TXDATA
               && q.size() == DEPTH;
    endfunction

    // Returns 0 when the expected value is unknown (unwritten RAM word).
    function automatic bit model_read(output logic [31:0] v);
        logic [31:0] a;
        a = bus.DMEM_addr;
        v = 32'h0;
        if (is_ram(a)) begin
            if (!mem_m.exists(int'(a[RAM_AW+1:2]))) return 0;
            v = mem_m[int'(a[RAM_AW+1:2])];
        end else if (wa(a) == ADDR_TXSTAT) begin
            v = (q.size() * 256) + (q.size() == 0 ? 2 : 0) + (q.size() == DEPTH ? 1 : 0);
        end else if (wa(a) == ADDR_CYCLE) begin
            v = cyc_m;
        end
        return 1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] v;
        if (model_read(v)) chk({tag, ".rdata"}, bus.DMEM_rdata, v);
        chk({tag, ".cpu_ena"}, 32'(bus.cpu_ena), model_stall() ? 32'h0 : 32'h1);
        chk({tag, ".tx_valid"}, 32'(bus.tx_valid), q.size() != 0 ? 32'h1 : 32'h0);
        chk({tag, ".tx_data"}, 32'(bus.tx_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
    endtask

    // Apply the current inputs to the model, then cross one rising edge.
    task automatic tick();
        bit stall, pop, push;
        logic [31:0] a;
        a     = bus.DMEM_addr;
        stall = model_stall();
        pop   = q.size() != 0 && bus.tx_ready;
        push  = bus.DMEM_we && !is_ram(a) && wa(a) == ADDR_TXDATA && q.size() < DEPTH;
        if (bus.DMEM_we && is_ram(a) && !stall) mem_m[int'(a[RAM_AW+1:2])] = bus.DMEM_wdata;
        if (bus.DMEM_we && !is_ram(a) && wa(a) == ADDR_CYCLE) cyc_m = bus.DMEM_wdata;
        else cyc_m = cyc_m + 32'd1;
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(bus.DMEM_wdata[7:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
        bus.DMEM_addr  = a;
        bus.DMEM_wdata = d;
        bus.DMEM_we    = we;
        bus.tx_ready   = rdy;
        #1;
    endtask

    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic we, input logic rdy);
        drive(a, d, we, rdy);
        check_outputs(tag);
        tick();
    endtask

    initial begin
        logic [31:0] exp_drain [4];
        logic [31:0] a, d;
        logic        w, r;
        int          op;

        // Reset state
        drive(ADDR_TXSTAT, 0, 0, 0);
        chk("rst.txstat", bus.DMEM_rdata, 32'h0000_0002);
        chk("rst.tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst.tx_data", 32'(bus.tx_data), 32'h0);
        chk("rst.cpu_ena", 32'(bus.cpu_ena), 32'h1);
        drive(ADDR_CYCLE, 0, 0, 0);
        chk("rst.cycle", bus.DMEM_rdata, 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        cyc_m = 32'h0;
        #1;

        // 1: RAM write/read, byte offset ignored
        step("t1.wr10", 32'h10, 32'h1234_5678, 1, 0);
        drive(32'h10, 0, 0, 0);
        chk("t1.rd10", bus.DMEM_rdata, 32'h1234_5678);
        drive(32'h13, 0, 0, 0);
        chk("t1.rd13", bus.DMEM_rdata, 32'h1234_5678);
        tick();
        step("t1.wr14", 32'h14, 32'h0000_00AA, 1, 0);
        drive(32'h14, 0, 0, 0);
        chk("t1.rd14", bus.DMEM_rdata, 32'h0000_00AA);
        tick();

        // 2: fill FIFO without a consumer
        for (int i = 0; i < 4; i++) begin
            drive(ADDR_TXDATA, 32'h41 + i, 1, 0);
            chk("t2.cpu_ena", 32'(bus.cpu_ena), 32'h1);
            check_outputs("t2.push");
            tick();
        end
        drive(ADDR_TXSTAT, 0, 0, 0);
        chk("t2.txstat", bus.DMEM_rdata, 32'h0000_0401);
        chk("t2.tx_data", 32'(bus.tx_data), 32'h41);
        tick();

        // 3: store to full FIFO stalls until a pop frees space
        for (int i = 0; i < 3; i++) begin
            drive(ADDR_TXDATA, 32'h45, 1, 0);
            chk("t3.stall", 32'(bus.cpu_ena), 32'h0);
            check_outputs("t3.hold");
            tick();
        end
        drive(ADDR_TXDATA, 32'h45, 1, 1);
        chk("t3.stall_pop", 32'(bus.cpu_ena), 32'h0);
        tick();
        drive(ADDR_TXDATA, 32'h45, 1, 0);
        chk("t3.resume", 32'(bus.cpu_ena), 32'h1);
        chk("t3.head42", 32'(bus.tx_data), 32'h42);
        tick();
        exp_drain = '{32'h42, 32'h43, 32'h44, 32'h45};
        for (int i = 0; i < 4; i++) begin
            drive(32'h0, 0, 0, 1);
            chk("t3.drain", 32'(bus.tx_data), exp_drain[i]);
            check_outputs("t3.drain_m");
            tick();
        end
        drive(ADDR_TXSTAT, 0, 0, 0);
        chk("t3.empty", bus.DMEM_rdata, 32'h0000_0002);
        tick();

        // 4: simultaneous push and pop at count 2
        step("t4.p50", ADDR_TXDATA, 32'h50, 1, 0);
        step("t4.p51", ADDR_TXDATA, 32'h51, 1, 0);
        step("t4.pushpop", ADDR_TXDATA, 32'h55, 1, 1);
        drive(ADDR_TXSTAT, 0, 0, 0);
        chk("t4.count2", bus.DMEM_rdata, 32'h0000_0200);
        chk("t4.head51", 32'(bus.tx_data), 32'h51);
        tick();
        drive(ADDR_TXSTAT, 0, 0, 1);
        tick();
        drive(ADDR_TXSTAT, 0, 0, 1);
        chk("t4.head55", 32'(bus.tx_data), 32'h55);
        tick();
        drive(ADDR_TXSTAT, 0, 0, 0);
        chk("t4.empty", bus.DMEM_rdata, 32'h0000_0002);
        chk("t4.tx_valid", 32'(bus.tx_valid), 32'h0);
        tick();

        // 5: cycle counter load and wrap
        step("t5.load", ADDR_CYCLE, 32'hFFFF_FFFE, 1, 0);
        drive(ADDR_CYCLE, 0, 0, 0);
        chk("t5.fffe", bus.DMEM_rdata, 32'hFFFF_FFFE);
        tick();
        drive(ADDR_CYCLE, 0, 0, 0);
        chk("t5.ffff", bus.DMEM_rdata, 32'hFFFF_FFFF);
        tick();
        drive(ADDR_CYCLE, 0, 0, 0);
        chk("t5.wrap", bus.DMEM_rdata, 32'h0000_0000);
        tick();

        // 6: asynchronous reset mid-cycle with bytes queued
        for (int i = 0; i < 3; i++) step("t6.fill", ADDR_TXDATA, 32'h60 + i, 1, 0);
        drive(ADDR_TXSTAT, 0, 0, 0);
        chk("t6.pre", bus.DMEM_rdata, 32'h0000_0300);
        #2;
        reset = 1'b1;
        #1;
        chk("t6.tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("t6.txstat", bus.DMEM_rdata, 32'h0000_0002);
        q.delete();
        cyc_m = 32'h0;
        drive(32'h10, 0, 0, 0);
        chk("t6.ram", bus.DMEM_rdata, 32'h1234_5678);
        drive(32'hFFFF_0010, 0, 0, 0);
        chk("t6.unmapped", bus.DMEM_rdata, 32'h0);
        #1;
        reset = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 7);
            d  = $urandom;
            r  = 1'($urandom_range(0, 1));
            w  = 1'b0;
            case (op)
                0: begin a = {20'h0, 6'($urandom_range(0, 63)), 6'h0} | 32'(($urandom_range(0, 15)) << 2); w = 1'b1; end
                1: a = 32'($urandom_range(0, 255)) & 32'hFF;
                2, 3: begin a = ADDR_TXDATA | 32'($urandom_range(0, 3)); w = 1'b1; end
                4: a = ADDR_TXSTAT;
                5: begin a = ADDR_CYCLE; w = ($urandom_range(0, 7) == 0); end
                6: begin a = 32'hFFFF_0010 + 32'($urandom_range(0, 3) * 4); w = 1'($urandom_range(0, 1)); end
                default: begin a = 32'h0001_0000 | 32'($urandom_range(0, 1023)); w = 1'($urandom_range(0, 1)); end
            endcase
            step("rnd", a, d, w, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
